ir_fetch_sequencer: RTL

- Multicycle fetch front-end that drives the 4-byte instruction register.
- Reads one instruction from the byte-wide memory at PC, PC+1, PC+2 and PC+3.
- Presents each byte with a one-hot byte-lane write strobe (IRWrite) so the instruction register assembles the 32-bit word, then advances PC by 4.
- Sits between the control unit (start/abort), the memory read port and the instruction register.

---
 rtl/ir_fetch_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ir_fetch_sequencer.sv
// Multicycle instruction fetch front-end: reads four bytes at PC..PC+3 and strobes them
// into the instruction register one byte lane at a time, then advances PC by 4.
module ir_fetch_sequencer #(
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              fetch_start,
  input  logic              fetch_abort,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready,
  output logic [3:0]        ir_write,
  output logic [7:0]        ir_byte,
  output logic [ADDR_W-1:0] pc_out,
  output logic              busy,
  output logic              fetch_done
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        idx_q, idx_d;
  logic              rd_q, rd_d;
  logic [3:0]        wr_q, wr_d;
  logic [7:0]        byte_q, byte_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      idx_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= '0;
      byte_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      byte_q  <= byte_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    rd_d    = 1'b0;
    wr_d    = '0;
    byte_d  = byte_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A simultaneous load takes effect first, so the fetch reads from pc_in.
        if (pc_load) begin
          pc_d = pc_in;
        end
        addr_d = pc_d;
        if (fetch_start) begin
          state_d = StReq;
          idx_d   = '0;
          rd_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end

      StReq: begin
        rd_d   = 1'b1;
        busy_d = 1'b1;
        if (fetch_abort) begin
          state_d = StIdle;
          rd_d    = 1'b0;
          busy_d  = 1'b0;
          idx_d   = '0;
          addr_d  = pc_q;
        end else if (mem_ready) begin
          byte_d = mem_rdata;
          wr_d   = 4'b0001 << idx_q;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = StDone;
            rd_d    = 1'b0;
            done_d  = 1'b1;
          end else begin
            addr_d = pc_q + ADDR_W'(idx_d);
          end
        end
      end

      StDone: begin
        state_d = StIdle;
        pc_d    = pc_q + ADDR_W'(4);
        addr_d  = pc_d;
        idx_d   = '0;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign mem_rd     = rd_q;
  assign mem_addr   = addr_q;
  assign ir_write   = wr_q;
  assign ir_byte    = byte_q;
  assign pc_out     = pc_q;
  assign busy       = busy_q;
  assign fetch_done = done_q;

  a_ir_write_onehot0 : assert property (@(posedge clock) disable iff (!reset_n)
    $onehot0(ir_write));

  a_busy_matches_state : assert property (@(posedge clock) disable iff (!reset_n)
    busy == (state_q != StIdle));

endmodule
